dmem_bridge: RTL

//  Sits between the rv32i core data-memory port and the data memory/bus. Latches one CPU

---
 rtl/dmem_bridge_pkg.sv | 12 +
 rtl/dmem_bridge.sv | 111 +++++++++++
 2 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared constants for the data-memory bridge:
// FSM state codes and the load write-mask encoding.
package dmem_bridge_pkg;

   localparam logic [1:0] DMB_IDLE = 2'd0;
   localparam logic [1:0] DMB_REQ  = 2'd1;
   localparam logic [1:0] DMB_WAIT = 2'd2;
   localparam logic [1:0] DMB_DONE = 2'd3;

   localparam logic [3:0] MEM_WMASK_LOAD = 4'b0000;

endpackage

// File: rtl/dmem_bridge.sv
// Core data port to variable-latency memory bridge:
// one outstanding access, req/ready + rvalid handshake, wait-cycle timeout.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int DMEM_WIDTH = 16,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic [DMEM_WIDTH-1:0] cpu_addr,
   input  logic [3:0]            cpu_wmask,
   input  logic [31:0]           cpu_wdata,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_valid,
   output logic                  cpu_err,
   output logic                  cpu_busy,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DMEM_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_wmask,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata
);

   localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [1:0] state_nx;
   logic [7:0] timer;
   logic       err_q;
   logic       take_rdata;
   logic       set_err;
   logic       is_load;
   logic       expired;

   assign is_load = (mem_wmask == MEM_WMASK_LOAD);
   assign expired = (timer == TLIM);

   // A completing handshake is checked before expiry so it wins a tie.
   always_comb begin
      state_nx   = state;
      take_rdata = 1'b0;
      set_err    = 1'b0;
      case (state)
         DMB_IDLE: begin
            if (cpu_req) state_nx = DMB_REQ;
         end
         DMB_REQ: begin
            if (mem_ready && !is_load) begin
               state_nx = DMB_DONE;
            end else if (mem_ready && mem_rvalid) begin
               state_nx   = DMB_DONE;
               take_rdata = 1'b1;
            end else if (expired) begin
               state_nx = DMB_DONE;
               set_err  = 1'b1;
            end else if (mem_ready) begin
               state_nx = DMB_WAIT;
            end
         end
         DMB_WAIT: begin
            if (mem_rvalid) begin
               state_nx   = DMB_DONE;
               take_rdata = 1'b1;
            end else if (expired) begin
               state_nx = DMB_DONE;
               set_err  = 1'b1;
            end
         end
         DMB_DONE: state_nx = DMB_IDLE;
         default:  state_nx = DMB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= DMB_IDLE;
         timer     <= 8'd0;
         err_q     <= 1'b0;
         mem_addr  <= '0;
         mem_wmask <= 4'd0;
         mem_wdata <= 32'd0;
         cpu_rdata <= 32'd0;
         cpu_valid <= 1'b0;
         cpu_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         cpu_valid <= (state == DMB_DONE);
         cpu_err   <= (state == DMB_DONE) && err_q;
         if (state == DMB_IDLE && cpu_req) begin
            mem_addr  <= cpu_addr;
            mem_wmask <= cpu_wmask;
            mem_wdata <= cpu_wdata;
            timer     <= 8'd0;
         end else if (state == DMB_REQ || state == DMB_WAIT) begin
            timer <= timer + 8'd1;
         end
         if (take_rdata) cpu_rdata <= mem_rdata;
         if (state_nx == DMB_DONE && state != DMB_DONE) err_q <= set_err;
      end
   end

   assign mem_req  = (state == DMB_REQ);
   assign mem_we   = (mem_wmask != MEM_WMASK_LOAD);
   assign cpu_busy = (state != DMB_IDLE);

endmodule
